// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the BRAM block reader and its read FIFO.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH          = 4;
  localparam int BLOCK_WORDS_DEFAULT = 64;

endpackage

// File: rtl/bram_block_reader_if.sv
// Command, BRAM read port and output stream of the block reader, bundled as one bus.
interface bram_block_reader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [15:0]           num_blocks;
  logic                  busy;
  logic                  done;
  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_dout;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (
    input  start, base_addr, num_blocks, bram_dout, m_tready,
    output busy, done, bram_en, bram_addr, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output start, base_addr, num_blocks, bram_dout, m_tready,
    input  busy, done, bram_en, bram_addr, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/bram_rd_fifo.sv
// Small registered FIFO for BRAM read data; no push-to-output bypass.
module bram_rd_fifo
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  do_push, do_pop;

  // A push into a full FIFO only lands when a pop frees the head slot that same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/bram_block_reader.sv
// Streams num_blocks*BLOCK_WORDS words from a 1-cycle-latency BRAM to a ready/valid
// stream, throttling reads so the 4-entry FIFO can never overflow.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FETCH | issuing BRAM reads
//   ST_DRAIN | all reads issued, emptying FIFO
//   ST_DONE  | one-cycle completion
module bram_block_reader
  import bram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
  input logic                 ACLK,
  input logic                 ARESET,
  bram_block_reader_if.master bus
);
  localparam int BW_LOG2  = $clog2(BLOCK_WORDS);
  localparam int RD_CNT_W = 16 + BW_LOG2;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  state_e                state_q, state_d;
  logic [RD_CNT_W-1:0]   rd_left_q, rd_left_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW_LOG2-1:0]    beat_q, beat_d;
  logic                  bram_en_q, bram_en_d;
  logic                  rd_vld_q;
  logic                  busy_q, done_q;
  logic [CNT_W-1:0]      fifo_cnt, occ_d;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty, push, pop;

  assign push  = rd_vld_q;
  assign pop   = !fifo_empty && bus.m_tready;
  assign occ_d = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d   = state_q;
    rd_left_d = rd_left_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    if (bram_en_q) begin
      rd_left_d = rd_left_q - RD_CNT_W'(1);
      addr_d    = addr_q + ADDR_WIDTH'(1);
    end
    if (pop) beat_d = beat_q + BW_LOG2'(1);
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        rd_left_d = {bus.num_blocks, {BW_LOG2{1'b0}}};
        addr_d    = bus.base_addr;
        beat_d    = '0;
        state_d   = (bus.num_blocks != '0) ? ST_FETCH : ST_DONE;
      end
      ST_FETCH: if (bram_en_q && (rd_left_q == RD_CNT_W'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if ((occ_d == '0) && !rd_vld_q && !bram_en_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Next-cycle occupancy plus the read issued this cycle bounds everything still to land.
    bram_en_d = (state_d == ST_FETCH) && (rd_left_d != '0) &&
                ((occ_d + CNT_W'(bram_en_q)) <= CNT_W'(2));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      rd_left_q <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
      bram_en_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_left_q <= rd_left_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      bram_en_q <= bram_en_d;
      rd_vld_q  <= bram_en_q;
      busy_q    <= (state_d == ST_FETCH) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  bram_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .push_i (push),
    .data_i (bus.bram_dout),
    .pop_i  (pop),
    .data_o (fifo_head),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bram_en   = bram_en_q;
  assign bus.bram_addr = addr_q;
  assign bus.m_tdata   = fifo_head;
  assign bus.m_tvalid  = !fifo_empty;
  assign bus.m_tlast   = !fifo_empty && (beat_q == BW_LOG2'(BLOCK_WORDS - 1));
endmodule

// File: tb/tb_bram_block_reader.sv
// Directed bench for bram_block_reader: BRAM model, scoreboard of addresses and beats,
// port-level FIFO occupancy model and stall-stability checks.
module tb_bram_block_reader;
  logic clk = 1'b0;
  logic areset;

  bram_block_reader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  bram_block_reader #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .BLOCK_WORDS(64)
  ) dut (
    .ACLK  (clk),
    .ARESET(areset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  always @(posedge clk) if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];

  int          vectors = 0;
  int          miscompares = 0;
  logic [9:0]  exp_addr_q[$];
  logic [32:0] exp_q[$];
  int          done_cnt = 0, beat_cnt = 0, en_cnt = 0, cyc = 0;
  int          first_beat_cyc = 0, last_beat_cyc = 0;
  bit          mark_first = 0;
  int          iss_prev = 0, iss_prev2 = 0, acc = 0;
  bit          stalled = 0;
  logic [31:0] held_data;
  logic        held_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Port-level monitor: FIFO occupancy is reads issued two or more cycles ago minus beats taken.
  always @(negedge clk) begin
    int occ;
    logic [9:0]  a;
    logic [32:0] e;
    cyc++;
    if (areset) begin
      iss_prev = 0; iss_prev2 = 0; acc = 0; stalled = 0;
    end else begin
      occ = iss_prev2 - acc;
      check("fifo_occ_le_4", 64'(occ <= 4), 64'd1);
      check("tvalid_eq_nonempty", 64'(bus.m_tvalid), 64'(occ != 0));
      if (stalled) begin
        check("stall_tvalid_held", 64'(bus.m_tvalid), 64'd1);
        check("stall_tdata_held", 64'(bus.m_tdata), 64'(held_data));
        check("stall_tlast_held", 64'(bus.m_tlast), 64'(held_last));
      end
      if (bus.bram_en) begin
        en_cnt++;
        if (exp_addr_q.size() == 0) check("unexpected_bram_read", 64'(bus.bram_en), 64'd0);
        else begin
          a = exp_addr_q.pop_front();
          check("bram_addr", 64'(bus.bram_addr), 64'(a));
        end
      end
      if (bus.m_tvalid && bus.m_tready) begin
        beat_cnt++;
        last_beat_cyc = cyc;
        if (mark_first) begin first_beat_cyc = cyc; mark_first = 0; end
        if (exp_q.size() == 0) check("unexpected_beat", 64'(bus.m_tvalid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("beat_tdata", 64'(bus.m_tdata), 64'(e[31:0]));
          check("beat_tlast", 64'(bus.m_tlast), 64'(e[32]));
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_busy_exclusive", 64'(bus.busy), 64'd0);
      end
      acc += int'(bus.m_tvalid && bus.m_tready);
      iss_prev2 = iss_prev;
      iss_prev += int'(bus.bram_en);
      stalled   = bus.m_tvalid && !bus.m_tready;
      held_data = bus.m_tdata;
      held_last = bus.m_tlast;
    end
  end

  task automatic launch(input logic [9:0] base, input logic [15:0] nb, input bit push_exp);
    if (push_exp) begin
      for (int i = 0; i < int'(nb) * 64; i++) begin
        logic [9:0] a;
        a = base + 10'(i);
        exp_addr_q.push_back(a);
        exp_q.push_back({(i % 64) == 63, mem[a]});
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.num_blocks = nb;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int pct, input int budget, input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      bus.m_tready = (int'($urandom_range(0, 99)) < pct);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic end_check(input string tag, input int d0, input int b0, input int beats);
    bus.m_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_beat_count"}, 64'(beat_cnt - b0), 64'(beats));
    check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_reads_left"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_done"},      64'(bus.done),      64'd0);
    check({tag, "_bram_en"},   64'(bus.bram_en),   64'd0);
    check({tag, "_bram_addr"}, 64'(bus.bram_addr), 64'd0);
    check({tag, "_m_tdata"},   64'(bus.m_tdata),   64'd0);
    check({tag, "_m_tvalid"},  64'(bus.m_tvalid),  64'd0);
    check({tag, "_m_tlast"},   64'(bus.m_tlast),   64'd0);
  endtask

  initial begin
    int d0, b0, e0, n;
    areset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_blocks = '0; bus.m_tready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    areset = 1'b0;
    bus.m_tready = 1'b1;
    repeat (2) @(posedge clk);

    // Single block, ready always high: 0x1..0x40, full throughput.
    d0 = done_cnt; b0 = beat_cnt; mark_first = 1;
    launch(10'h000, 16'd1, 1'b1);
    check("single_bram_en_after_start", 64'(bus.bram_en), 64'd1);
    check("single_busy_after_start", 64'(bus.busy), 64'd1);
    wait_done(100, 500, d0, "single");
    end_check("single", d0, b0, 64);
    check("single_throughput", 64'(last_beat_cyc - first_beat_cyc), 64'd63);

    // Two blocks with 30% ready.
    d0 = done_cnt; b0 = beat_cnt;
    launch(10'h100, 16'd2, 1'b1);
    check("bp_busy_after_start", 64'(bus.busy), 64'd1);
    wait_done(30, 5000, d0, "backpressure");
    end_check("backpressure", d0, b0, 128);

    // Address wrap from 0x3F0.
    d0 = done_cnt; b0 = beat_cnt;
    launch(10'h3F0, 16'd1, 1'b1);
    wait_done(100, 500, d0, "wrap");
    end_check("wrap", d0, b0, 64);

    // Zero block count: done without any read.
    d0 = done_cnt; b0 = beat_cnt; e0 = en_cnt;
    launch(10'h055, 16'd0, 1'b1);
    wait_done(100, 2, d0, "zero");
    end_check("zero", d0, b0, 0);
    check("zero_no_bram_en", 64'(en_cnt - e0), 64'd0);

    // Second start while busy is ignored.
    d0 = done_cnt; b0 = beat_cnt;
    launch(10'h000, 16'd1, 1'b1);
    repeat (10) @(posedge clk);
    launch(10'h200, 16'd5, 1'b0);
    wait_done(100, 500, d0, "start_busy");
    end_check("start_busy", d0, b0, 64);

    // Reset after 20 beats, then a clean run.
    d0 = done_cnt; b0 = beat_cnt; n = 0;
    launch(10'h040, 16'd2, 1'b1);
    while (beat_cnt - b0 < 20 && n < 200) begin @(posedge clk); #1; n++; end
    check("mid_reset_reached_20_beats", 64'(beat_cnt - b0 >= 20), 64'd1);
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    check_zero_outputs("mid_reset");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt; b0 = beat_cnt;
    launch(10'h080, 16'd1, 1'b1);
    wait_done(100, 500, d0, "after_reset");
    end_check("after_reset", d0, b0, 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
